rf_write_arbiter: RTL

//  Owns the single write port of register_file and shares it between two requesters:
//  req0 (ALU writeback) and req1 (memory load return).

---
 rtl/rf_write_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin owner of the register_file write port, shared between the ALU
// writeback and load return paths, plus a software clear that zeroes r1..rN-1.
module rf_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_dest,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_dest,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data
);

  typedef enum logic {ARB, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_PTR  = '1;

  state_t            state;
  logic              rr_last;
  logic [ADDR_W-1:0] clr_ptr;
  logic              arb_open;

  // Grants look only at valids, state, rr_last and clear_req so a requester's
  // dest/data can never feed back into its own ready.
  always_comb begin
    arb_open   = (state == ARB) && !clear_req;
    req0_ready = arb_open && req0_valid && (!req1_valid || rr_last);
    req1_ready = arb_open && req1_valid && (!req0_valid || !rr_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ARB;
      rr_last        <= 1'b1;
      clr_ptr        <= FIRST_PTR;
      reg_write_en   <= 1'b0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
      clear_busy     <= 1'b0;
      clear_done     <= 1'b0;
    end else begin
      reg_write_en <= 1'b0;
      clear_done   <= 1'b0;
      case (state)
        ARB: begin
          if (clear_req) begin
            state      <= CLEAR;
            clear_busy <= 1'b1;
            clr_ptr    <= FIRST_PTR;
          end else if (req0_ready) begin
            // A grant to r0 is still consumed, it just never reaches the file.
            rr_last <= 1'b0;
            if (req0_dest != '0) begin
              reg_write_en   <= 1'b1;
              reg_write_dest <= req0_dest;
              reg_write_data <= req0_data;
            end
          end else if (req1_ready) begin
            rr_last <= 1'b1;
            if (req1_dest != '0) begin
              reg_write_en   <= 1'b1;
              reg_write_dest <= req1_dest;
              reg_write_data <= req1_data;
            end
          end
        end
        CLEAR: begin
          reg_write_en   <= 1'b1;
          reg_write_dest <= clr_ptr;
          reg_write_data <= '0;
          if (clr_ptr == LAST_PTR) begin
            state      <= ARB;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
            clr_ptr    <= FIRST_PTR;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
